// File: rtl/darkriscv_data_bridge.sv
// Bridges the darkriscv strobe-style data port onto a held request/response memory port.
// Sub-word stores become read-modify-write; misaligned or timed-out accesses set a sticky error.
module darkriscv_data_bridge #(
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter logic [31:0] ERROR_READ_DATA = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_drd,
    input  logic        core_dwr,
    input  logic [31:0] core_daddr,
    input  logic [31:0] core_datao,
    input  logic [2:0]  core_dlen,
    output logic [31:0] core_datai,
    output logic        core_hlt,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_response,
    output logic        err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, READ, RMW_READ, RMW_WRITE, WRITE, DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [2:0]       dlen_q, dlen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic             err_q, err_d;
    logic [31:0]      datai_q, datai_d;
    logic             strobe;
    logic             timed_out;
    logic [31:0]      bit_mask;

    function automatic logic [3:0] byte_mask(input logic [2:0] dlen, input logic [1:0] a);
        case (dlen)
            3'b001:  byte_mask = 4'b0001 << a;
            3'b010:  byte_mask = 4'b0011 << a;
            default: byte_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] expand_mask(input logic [3:0] m);
        expand_mask = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    function automatic logic is_aligned(input logic [2:0] dlen, input logic [1:0] a);
        case (dlen)
            3'b001:  is_aligned = 1'b1;
            3'b010:  is_aligned = ~a[0];
            3'b100:  is_aligned = (a == 2'b00);
            default: is_aligned = 1'b0;
        endcase
    endfunction

    always_comb begin
        strobe    = core_drd | core_dwr;
        timed_out = (cnt_q == CNT_LAST);
        bit_mask  = expand_mask(byte_mask(dlen_q, addr_q[1:0]));

        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        dlen_d      = dlen_q;
        cnt_d       = cnt_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        err_d       = err_q;
        datai_d     = datai_q;

        case (state_q)
            IDLE: begin
                if (strobe) begin
                    addr_d = core_daddr;
                    data_d = core_datao;
                    dlen_d = core_dlen;
                    cnt_d  = '0;
                    if (!is_aligned(core_dlen, core_daddr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                        if (core_drd) datai_d = ERROR_READ_DATA;
                    end else if (core_drd) begin
                        mem_read_d = 1'b1;
                        state_d    = READ;
                    end else if (core_dlen == 3'b100) begin
                        mem_write_d = 1'b1;
                        state_d     = WRITE;
                    end else begin
                        mem_read_d = 1'b1;
                        state_d    = RMW_READ;
                    end
                end
            end
            READ, RMW_READ: begin
                if (mem_response) begin
                    mem_read_d = 1'b0;
                    cnt_d      = '0;
                    if (state_q == READ) begin
                        datai_d = mem_read_data;
                        state_d = DONE;
                    end else begin
                        // The merged word replaces the captured store data and is held for the write.
                        data_d      = (mem_read_data & ~bit_mask) | (data_q & bit_mask);
                        mem_write_d = 1'b1;
                        state_d     = RMW_WRITE;
                    end
                end else if (timed_out) begin
                    mem_read_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = DONE;
                    if (state_q == READ) datai_d = ERROR_READ_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITE, RMW_WRITE: begin
                if (mem_response) begin
                    mem_write_d = 1'b0;
                    state_d     = DONE;
                end else if (timed_out) begin
                    mem_write_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            dlen_q      <= '0;
            cnt_q       <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            err_q       <= 1'b0;
            datai_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            dlen_q      <= dlen_d;
            cnt_q       <= cnt_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            err_q       <= err_d;
            datai_q     <= datai_d;
        end
    end

    // The stall is raised combinationally in the capture cycle so the core never runs past a strobe.
    assign core_hlt       = ((state_q != IDLE) && (state_q != DONE)) || ((state_q == IDLE) && strobe);
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = {addr_q[31:2], 2'b00};
    assign mem_write_data = data_q;
    assign core_datai     = datai_q;
    assign err            = err_q;

endmodule

// File: tb/tb_darkriscv_data_bridge.sv
// Randomized bench for darkriscv_data_bridge with a memory responder and a word-level reference model.
module tb_darkriscv_data_bridge;

    localparam int          TMO  = 8;
    localparam logic [31:0] ERRD = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_drd, core_dwr;
    logic [31:0] core_daddr, core_datao;
    logic [2:0]  core_dlen;
    logic [31:0] core_datai;
    logic        core_hlt;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_response;
    logic        err;

    int          vectors;
    int          miscompares;
    logic [31:0] tbmem  [16];
    logic [31:0] refmem [16];
    logic [31:0] datai_exp;
    logic        err_exp;

    always #5 clk = ~clk;

    darkriscv_data_bridge #(.TIMEOUT_CYCLES(TMO), .ERROR_READ_DATA(ERRD)) dut (
        .clk(clk), .reset(reset),
        .core_drd(core_drd), .core_dwr(core_dwr), .core_daddr(core_daddr),
        .core_datao(core_datao), .core_dlen(core_dlen), .core_datai(core_datai),
        .core_hlt(core_hlt), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_response(mem_response), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One core access; hold_phase selects which memory phase (0/1) never gets a response, -1 for none.
    task automatic do_access(input bit rd, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [2:0] dlen, input int lat0, input int lat1,
                             input int hold_phase);
        int          nph, stall_exp, rd_exp, wr_exp, stall, rd_ph, wr_ph, phase, w, lat, sz, off;
        bit          legal, tmo, done, overlap, addr_bad, prev_r, prev_w;
        logic [3:0]  idx;
        logic [31:0] aw;

        idx   = addr[5:2];
        aw    = {addr[31:2], 2'b00};
        off   = int'(addr[1:0]);
        sz    = (dlen == 3'b001) ? 1 : (dlen == 3'b010) ? 2 : 4;
        legal = (dlen == 3'b001) || (dlen == 3'b010 && off % 2 == 0) || (dlen == 3'b100 && off == 0);
        nph   = (rd || dlen == 3'b100) ? 1 : 2;
        tmo   = legal && hold_phase >= 0 && hold_phase < nph;

        stall_exp = 1;
        if (legal) begin
            for (int p = 0; p < nph; p++) begin
                if (p == hold_phase) begin
                    stall_exp += TMO;
                    break;
                end
                stall_exp += ((p == 0) ? lat0 : lat1) + 1;
            end
        end
        rd_exp = (legal && (rd || nph == 2)) ? 1 : 0;
        wr_exp = (legal && !rd && !(nph == 2 && hold_phase == 0)) ? 1 : 0;

        if (legal && !tmo) begin
            if (rd) datai_exp = refmem[idx];
            else begin
                for (int b = 0; b < 4; b++)
                    if (b >= off && b < off + sz) refmem[idx][b*8 +: 8] = wdata[b*8 +: 8];
            end
        end else if (rd) begin
            datai_exp = ERRD;
        end
        if (!legal || tmo) err_exp = 1'b1;

        @(negedge clk);
        core_drd = rd; core_dwr = !rd; core_daddr = addr; core_datao = wdata; core_dlen = dlen;
        stall = 0; rd_ph = 0; wr_ph = 0; phase = 0; w = 0;
        done = 0; overlap = 0; addr_bad = 0; prev_r = 0; prev_w = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            #1;
            if (mem_read && mem_write) overlap = 1;
            if (mem_read && !prev_r) rd_ph++;
            if (mem_write && !prev_w) wr_ph++;
            prev_r = mem_read;
            prev_w = mem_write;
            mem_read_data = $urandom();
            if (mem_read || mem_write) begin
                if (mem_address !== aw) addr_bad = 1;
                lat = (phase == 0) ? lat0 : lat1;
                if (phase != hold_phase && w >= lat) begin
                    mem_response = 1'b1;
                    if (mem_read) mem_read_data = tbmem[idx];
                    else tbmem[idx] = mem_write_data;
                    phase++;
                    w = 0;
                end else begin
                    w++;
                end
            end
            if (core_hlt) stall++;
            else begin
                done = 1;
                check("datai", core_datai, datai_exp);
                check("err", {31'b0, err}, {31'b0, err_exp});
                mem_response = ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            mem_response = 1'b0;
        end
        core_drd = 1'b0;
        core_dwr = 1'b0;
        check("done", {31'b0, done}, 32'd1);
        check("stall_cycles", stall, stall_exp);
        check("read_phases", rd_ph, rd_exp);
        check("write_phases", wr_ph, wr_exp);
        check("rd_wr_overlap", {31'b0, overlap}, 32'd0);
        check("mem_address", {31'b0, addr_bad}, 32'd0);
        check("mem_word", tbmem[idx], refmem[idx]);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  dl;
        int          r, hp;
        bit          seen;

        vectors = 0; miscompares = 0;
        reset = 1'b1;
        core_drd = 0; core_dwr = 0; core_daddr = 0; core_datao = 0; core_dlen = 0;
        mem_read_data = 0; mem_response = 0;
        err_exp = 0; datai_exp = 0;
        for (int i = 0; i < 16; i++) begin
            tbmem[i]  = $urandom();
            refmem[i] = tbmem[i];
        end

        repeat (3) @(negedge clk);
        #1;
        check("rst_mem_read", {31'b0, mem_read}, 32'd0);
        check("rst_mem_write", {31'b0, mem_write}, 32'd0);
        check("rst_hlt", {31'b0, core_hlt}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_datai", core_datai, 32'd0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_wdata", mem_write_data, 32'd0);
        reset = 1'b0;

        tbmem[0] = 32'h12345678; refmem[0] = 32'h12345678;
        do_access(1'b1, 32'h0000_0100, 32'h0, 3'b100, 0, 0, -1);
        check("ld_word_value", core_datai, 32'h12345678);

        do_access(1'b0, 32'h0000_0204, 32'hCAFEBABE, 3'b100, 1, 0, -1);
        check("st_word_mem", tbmem[1], 32'hCAFEBABE);

        tbmem[0] = 32'h11223344; refmem[0] = 32'h11223344;
        do_access(1'b0, 32'h0000_0302, 32'h00AB0000, 3'b001, 0, 0, -1);
        check("st_byte_merge", tbmem[0], 32'h11AB3344);

        do_access(1'b0, 32'h0000_0401, 32'h0000BEEF, 3'b010, 0, 0, -1);
        check("misalign_err", {31'b0, err}, 32'd1);
        do_access(1'b1, 32'h0000_0108, 32'h0, 3'b100, 2, 0, -1);
        check("err_sticky", {31'b0, err}, 32'd1);

        do_access(1'b1, 32'h0000_0110, 32'h0, 3'b100, 0, 0, 0);
        check("timeout_datai", core_datai, ERRD);

        for (int n = 0; n < 300; n++) begin
            r  = $urandom_range(0, 9);
            dl = (r == 0) ? 3'($urandom_range(0, 7)) :
                 (r < 4)  ? 3'b001 : (r < 7) ? 3'b010 : 3'b100;
            a  = $urandom();
            if ($urandom_range(0, 3) != 0) begin
                if (dl == 3'b010) a[0] = 1'b0;
                if (dl == 3'b100) a[1:0] = 2'b00;
            end
            hp = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 1)) : -1;
            do_access(1'($urandom_range(0, 1)), a, $urandom(), dl,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), hp);
        end

        tbmem[3] = 32'hA5A50001; refmem[3] = 32'hA5A50001;
        do_access(1'b1, 32'h0000_000C, 32'h0, 3'b100, 0, 0, -1);

        @(negedge clk);
        core_dwr = 1'b1; core_daddr = 32'h0000_0031; core_datao = 32'h00005500; core_dlen = 3'b001;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (mem_write) seen = 1;
            else begin
                mem_response  = mem_read;
                mem_read_data = tbmem[12];
                @(negedge clk);
                mem_response = 1'b0;
            end
        end
        check("reach_rmw_write", {31'b0, seen}, 32'd1);
        reset = 1'b1;
        core_dwr = 1'b0;
        #1;
        check("midrst_mem_write", {31'b0, mem_write}, 32'd0);
        check("midrst_mem_read", {31'b0, mem_read}, 32'd0);
        check("midrst_hlt", {31'b0, core_hlt}, 32'd0);
        check("midrst_err", {31'b0, err}, 32'd0);
        check("midrst_datai", core_datai, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        err_exp = 1'b0;
        datai_exp = 32'd0;
        do_access(1'b1, 32'h0000_000C, 32'h0, 3'b100, 1, 0, -1);
        check("post_rst_load", core_datai, 32'hA5A50001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
